// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory bridge: access sizes, FSM states, default RAM base.
package dmem_pkg;

   localparam logic [31:0] BASE_ADDR_DEF = 32'h1001_0000;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {IDLE, RD, WR, RESP, FLT} state_e;

endpackage

// File: rtl/dmem_bridge_if.sv
// CPU data-port bus between the core (master) and the memory bridge (slave).
interface dmem_bridge_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [1:0]  size;
   logic        sext;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        fault;

   modport master (
      output req, we, addr, size, sext, wdata,
      input  rdata, ready, fault
   );

   modport slave (
      input  req, we, addr, size, sext, wdata,
      output rdata, ready, fault
   );
endinterface

// File: rtl/lane_unit.sv
// Byte-lane steering: load extract/extend and sub-word store merge over a 32-bit RAM word.
module lane_unit
   import dmem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_sext,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_rword,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_store_word
);

   logic [4:0]  w_shamt;
   logic [31:0] w_rsh;
   logic [31:0] w_wsh;
   logic [3:0]  w_be;

   always_comb begin
      w_shamt = {i_lane, 3'b000};
      w_rsh   = i_rword >> w_shamt;
      w_wsh   = i_wdata << w_shamt;

      o_load_data = i_rword;
      w_be        = 4'b1111;
      case (i_size)
         SZ_BYTE: begin
            o_load_data = {{24{i_sext & w_rsh[7]}}, w_rsh[7:0]};
            w_be        = 4'b0001 << i_lane;
         end
         SZ_HALF: begin
            o_load_data = {{16{i_sext & w_rsh[15]}}, w_rsh[15:0]};
            w_be        = 4'b0011 << i_lane;
         end
         default: ;
      endcase

      o_store_word = i_rword;
      for (int k = 0; k < 4; k++) begin
         if (w_be[k]) o_store_word[8*k +: 8] = w_wsh[8*k +: 8];
      end
   end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: CPU byte addresses to RAM word accesses, sub-word loads and RMW stores.
module dmem_bridge
   import dmem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
   parameter int unsigned ADDR_W    = 9
) (
   input  logic              clk_in,
   input  logic              reset,
   dmem_bridge_if.slave      bus,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   state_e              r_state,     w_state_d;
   logic                r_rd_wait,   w_rd_wait_d;
   logic                r_we,        w_we_d;
   logic [1:0]          r_size,      w_size_d;
   logic                r_sext,      w_sext_d;
   logic [1:0]          r_lane,      w_lane_d;
   logic [31:0]         r_wdata,     w_wdata_d;
   logic [ADDR_W-1:0]   r_ram_addr,  w_ram_addr_d;
   logic [31:0]         r_ram_wdata, w_ram_wdata_d;
   logic [31:0]         r_rdata,     w_rdata_d;

   logic [31:0]         w_off;
   logic [ADDR_W-1:0]   w_idx;
   logic [1:0]          w_lane;
   logic                w_fault;
   logic [31:0]         w_load_data;
   logic [31:0]         w_store_word;

   assign w_off  = bus.addr - BASE_ADDR;
   assign w_idx  = w_off[ADDR_W+1:2];
   assign w_lane = w_off[1:0];

   assign w_fault = (|w_off[31:ADDR_W+2])
                  | (bus.size == 2'd3)
                  | ((bus.size == SZ_HALF) & w_lane[0])
                  | ((bus.size == SZ_WORD) & (w_lane != 2'd0));

   lane_unit u_lane (
      .i_size       (r_size),
      .i_sext       (r_sext),
      .i_lane       (r_lane),
      .i_rword      (ram_rdata),
      .i_wdata      (r_wdata),
      .o_load_data  (w_load_data),
      .o_store_word (w_store_word)
   );

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_rd_wait   <= 1'b0;
         r_we        <= 1'b0;
         r_size      <= SZ_BYTE;
         r_sext      <= 1'b0;
         r_lane      <= 2'd0;
         r_wdata     <= '0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_rdata     <= '0;
      end else begin
         r_state     <= w_state_d;
         r_rd_wait   <= w_rd_wait_d;
         r_we        <= w_we_d;
         r_size      <= w_size_d;
         r_sext      <= w_sext_d;
         r_lane      <= w_lane_d;
         r_wdata     <= w_wdata_d;
         r_ram_addr  <= w_ram_addr_d;
         r_ram_wdata <= w_ram_wdata_d;
         r_rdata     <= w_rdata_d;
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_rd_wait_d   = r_rd_wait;
      w_we_d        = r_we;
      w_size_d      = r_size;
      w_sext_d      = r_sext;
      w_lane_d      = r_lane;
      w_wdata_d     = r_wdata;
      w_ram_addr_d  = r_ram_addr;
      w_ram_wdata_d = r_ram_wdata;
      w_rdata_d     = r_rdata;

      case (r_state)
         IDLE: begin
            if (bus.req) begin
               if (w_fault) begin
                  w_rdata_d = '0;
                  w_state_d = FLT;
               end else begin
                  w_we_d       = bus.we;
                  w_size_d     = bus.size;
                  w_sext_d     = bus.sext;
                  w_lane_d     = w_lane;
                  w_wdata_d    = bus.wdata;
                  w_ram_addr_d = w_idx;
                  if (bus.we) w_rdata_d = '0;
                  if (bus.we && bus.size == SZ_WORD) begin
                     w_ram_wdata_d = bus.wdata;
                     w_state_d     = WR;
                  end else begin
                     w_rd_wait_d = ~bus.we;
                     w_state_d   = RD;
                  end
               end
            end
         end
         RD: begin
            // Loads dwell one extra RD cycle so every load completes in a fixed 3 cycles.
            if (!r_we && r_rd_wait) begin
               w_rd_wait_d = 1'b0;
            end else if (!r_we) begin
               w_rdata_d = w_load_data;
               w_state_d = RESP;
            end else begin
               w_ram_wdata_d = w_store_word;
               w_state_d     = WR;
            end
         end
         WR:      w_state_d = RESP;
         RESP:    w_state_d = IDLE;
         FLT:     w_state_d = IDLE;
         default: w_state_d = IDLE;
      endcase
   end

   // Address is driven straight from the request in IDLE so RAM data is ready in the RD cycle.
   assign ram_addr  = (r_state == IDLE && bus.req && !w_fault && reset) ? w_idx : r_ram_addr;
   assign ram_we    = (r_state == WR);
   assign ram_wdata = r_ram_wdata;

   assign bus.ready = (r_state == RESP) || (r_state == FLT);
   assign bus.fault = (r_state == FLT);
   assign bus.rdata = r_rdata;

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory interface stage between the single-cycle CPU core's data port and the synchronous word-wide data RAM.
- Translates CPU byte addresses (base 0x1001_0000) into RAM word indices.
- Performs byte and halfword loads with sign or zero extension.
- Performs sub-word stores by read-modify-write.
- Flags misaligned and out-of-range accesses; signals completion to the core with a one-cycle ready pulse.

Parameters:
- BASE_ADDR, 32'h1001_0000, byte address that maps to RAM word 0.
- ADDR_W, 9, RAM word-index width; RAM depth is 2^ADDR_W words (2 KiB at default).

Ports:
- clk_in, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- req, in, 1: access request; held stable with all request fields until ready is seen.
- we, in, 1: 1 = store, 0 = load.
- addr, in, 32: CPU byte address.
- size, in, 2: 0 = byte, 1 = halfword, 2 = word; 3 is illegal and faults.
- sext, in, 1: loads only; 1 = sign-extend, 0 = zero-extend.
- wdata, in, 32: store data, right-aligned (bits [7:0] for byte, [15:0] for half).
- rdata, out, 32: load result; valid only while ready = 1.
- ready, out, 1: one-cycle completion pulse.
- fault, out, 1: asserted with ready when the access was rejected.
- ram_addr, out, ADDR_W: RAM word index.
- ram_we, out, 1: RAM write enable.
- ram_wdata, out, 32: RAM write word.
- ram_rdata, in, 32: RAM read word; synchronous, valid the cycle after ram_addr is presented.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE immediately.
  - ready, fault, ram_we = 0; rdata, ram_addr, ram_wdata = 0.
  - An in-flight access is abandoned with no RAM write; ram_we drops without waiting for a clock edge.
- Offset calculation: off = addr - BASE_ADDR (32-bit, wraps); word index = off[ADDR_W+1:2]; lane = off[1:0].
- Fault conditions (checked in IDLE on req):
  - off >= 4 * 2^ADDR_W;
  - size = 3;
  - size = 1 with lane[0] = 1;
  - size = 2 with lane != 0.
- Byte lanes are little-endian: byte k occupies bits [8k+7:8k]; a halfword at lane 0 or 2 occupies bytes lane and lane+1.
- State machine: IDLE, RD, WR, RESP, FLT.
  - IDLE, req = 0: stay.
  - IDLE, req = 1 and fault condition: go to FLT.
  - IDLE, load: drive ram_addr; go to RD.
  - IDLE, word store: go to WR.
  - IDLE, byte or half store: drive ram_addr; go to RD.
  - RD, load: extract the lane from ram_rdata, extend per sext, register into rdata; go to RESP.
  - RD, sub-word store: merge the shifted wdata into the ram_rdata lanes; register into ram_wdata; go to WR.
  - WR: ram_we = 1 for exactly one cycle with ram_addr and ram_wdata stable; go to RESP.
  - RESP: ready = 1; go to IDLE.
  - FLT: ready = 1, fault = 1, rdata = 0, no RAM access; go to IDLE.
- Latency (cycles from the accepting edge to the ready cycle):
  - load: 3;
  - word store: 2;
  - sub-word store: 3;
  - fault: 1.
- Request acceptance:
  - A new req is accepted only in IDLE, so back-to-back accesses always have one IDLE bubble.
  - req is ignored outside IDLE.
  - rdata holds its last load value while ready = 0; consumers must sample it only with ready.
- ram_we is decoded combinationally from state == WR and is never asserted in any other state.
- rdata is updated only on loads; stores and faults clear it to 0.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum {IDLE, RD, WR, RESP, FLT};
  - BASE_ADDR default.
- Sub-module lane_unit (combinational):
  - extract plus extend for loads;
  - byte-enable generation plus merge for stores;
  - shared by the RD-state logic and unit-testable on its own.

Test Plan:
- Word store then load: sw 0xDEADBEEF to 0x1001_0004 → ram_we one cycle, ram_addr = 1, ram_wdata = 0xDEADBEEF, ready 2 cycles after accept. lw from the same address → rdata = 0xDEADBEEF, ready 3 cycles after accept.
- Byte store merge: RAM word 1 = 0xDEADBEEF; sb 0x55 to 0x1001_0006 → ram_wdata = 0xDE55BEEF. Then lb at 0x1001_0007 with sext = 1 → 0xFFFFFFDE; lbu → 0x000000DE.
- Halfword: sh 0x8001 to 0x1001_0008 over a RAM word of 0 → ram_wdata = 0x00008001. lh with sext = 1 → 0xFFFF8001; lhu → 0x00008001.
- Faults, each giving ready = fault = 1 one cycle after accept and ram_we never asserted:
  - lw at 0x1001_0002;
  - sh at 0x1001_0001;
  - size = 3;
  - addr 0x1001_0800;
  - addr 0x1000_FFFC (wrapped offset).
- Reset mid-store: drive reset low during the RD cycle of an sb → ram_we stays 0, RAM is unchanged, outputs are 0. After release, the next lw returns the original word.
- Back-to-back: hold req high across two consecutive sw transactions → exactly one ram_we pulse per transaction, with an IDLE bubble between them.
